// File: rtl/lut_ram_wr_sched_pkg.sv
// Shared types and constants for the LUT RAM write-port scheduler.
package lut_ram_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } sched_state_e;

    typedef logic req_idx_t;

    // One-hot grant vector for a requester index.
    function automatic logic [NUM_REQ-1:0] idx_to_onehot(req_idx_t idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/lut_ram_wr_sched_if.sv
// Requester-side bus of the LUT RAM write scheduler (two update agents).
//
// Handshake: requester r raises req_valid[r] with req_addr[r]/req_data[r] and
// holds all three stable until it sees req_ready[r]. The write completes at the
// posedge where req_valid[r] & req_ready[r] are both high. req_ready is one-hot
// or zero and never asserted to a requester that is not valid.
interface lut_ram_wr_sched_if #(
    parameter int AW    = 8,
    parameter int WIDTH = 32
);
    import lut_ram_pkg::*;

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0][AW-1:0]    req_addr;
    logic [NUM_REQ-1:0][WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;

    modport master (output req_valid, req_addr, req_data, input req_ready);
    modport slave  (input req_valid, req_addr, req_data, output req_ready);

endinterface

// File: rtl/lut_ram_wr_sched_rr_arb2.sv
// Two-way round-robin arbiter. Grant is combinational; the last winner is
// remembered only when the caller reports a completed handshake via ack.
module rr_arb2
    import lut_ram_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               ack,
    output logic [NUM_REQ-1:0] gnt
);

    req_idx_t last_grant;

    // Sole requester wins; on a tie the requester that did not win last time wins.
    always_comb begin
        gnt = '0;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = idx_to_onehot(req_idx_t'(~last_grant));
            default: gnt = '0;
        endcase
    end

    // Remember the winner of each completed handshake; reset favours req 0 next.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (ack) begin
            last_grant <= req_idx_t'(gnt[1]);
        end
    end

endmodule

// File: rtl/lut_ram_wr_sched.sv
// LUT RAM write-port scheduler: walks every entry writing INIT_VALUE after
// reset or clear, then shares the write port between two requesters with
// round-robin arbitration.
// Optional build macro LUT_RAM_WR_SCHED_STATS_EN adds saturating per-requester
// handshake counters on ports grant_cnt0/grant_cnt1.
module lut_ram_wr_sched
    import lut_ram_pkg::*;
#(
    parameter int                   LUT_WIDTH  = 32,
    parameter int                   LUT_DEPTH  = 256,
    parameter logic [LUT_WIDTH-1:0] INIT_VALUE = '0,
    localparam int                  AW         = (LUT_DEPTH > 1) ? $clog2(LUT_DEPTH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    lut_ram_wr_sched_if.slave    req_if,
    output logic                 init_done,
    output logic                 wr_en,
    output logic [AW-1:0]        wr_addr,
    output logic [LUT_WIDTH-1:0] wr_data,
    output sched_state_e         dbg_state
`ifdef LUT_RAM_WR_SCHED_STATS_EN
    ,
    output logic [31:0]          grant_cnt0,
    output logic [31:0]          grant_cnt1
`endif
);

    sched_state_e       state;
    sched_state_e       state_nxt;
    logic [AW-1:0]      init_cnt;
    logic               last_init;
    logic [NUM_REQ-1:0] arb_req;
    logic [NUM_REQ-1:0] gnt;
    logic               hs;

    assign last_init = (init_cnt == AW'(LUT_DEPTH - 1));
    assign dbg_state = state;

    // Requests are only visible to the arbiter in RUN and never in a clear cycle.
    assign arb_req = (state == RUN && !clear) ? req_if.req_valid : '0;
    assign hs      = |gnt;

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req (arb_req),
        .ack (hs),
        .gnt (gnt)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: leave INIT after the last entry is written; clear in RUN restarts the walk.
    always_comb begin
        state_nxt = state;
        case (state)
            INIT:    if (last_init) state_nxt = RUN;
            RUN:     if (clear)     state_nxt = INIT;
            default: state_nxt = INIT;
        endcase
    end

    // Init address counter: advances every INIT cycle, parked at 0 otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_cnt <= '0;
        end else if (state == INIT && !last_init) begin
            init_cnt <= init_cnt + 1'b1;
        end else begin
            init_cnt <= '0;
        end
    end

    // Outputs: init write in INIT, granted requester muxed onto the port in RUN; all quiet during rst.
    always_comb begin
        wr_en            = 1'b0;
        wr_addr          = '0;
        wr_data          = '0;
        req_if.req_ready = '0;
        init_done        = 1'b0;
        if (!rst) begin
            case (state)
                INIT: begin
                    wr_en   = 1'b1;
                    wr_addr = init_cnt;
                    wr_data = INIT_VALUE;
                end
                RUN: begin
                    init_done        = 1'b1;
                    req_if.req_ready = gnt;
                    if (hs) begin
                        wr_en   = 1'b1;
                        wr_addr = req_if.req_addr[gnt[1]];
                        wr_data = req_if.req_data[gnt[1]];
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef LUT_RAM_WR_SCHED_STATS_EN
    // Per-requester completed-handshake counters, saturating, zeroed by clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else if (clear) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (gnt[0] && grant_cnt0 != 32'hFFFF_FFFF) grant_cnt0 <= grant_cnt0 + 32'd1;
            if (gnt[1] && grant_cnt1 != 32'hFFFF_FFFF) grant_cnt1 <= grant_cnt1 + 32'd1;
        end
    end
`endif

endmodule
